// File: rtl/clip_mac_pkg.sv
// Shared defaults and saturation helpers for the multi-lane clip MAC.
package clip_mac_pkg;

  localparam int CM_W     = 8;
  localparam int CM_LANES = 4;
  localparam int CM_ACC_W = 24;
  localparam int CM_OUT_W = 8;
  localparam int CM_SH_W  = 5;

  // fp_mode value selecting an unsigned (zero-extended) in0 operand
  localparam logic [1:0] FP_MODE_UNSIGNED = 2'b00;

  // Largest value representable in a signed field of the given width
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed field of the given width
  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/clip_mac_lane.sv
// One lane of the clip MAC: product register, saturating accumulator with
// sticky overflow flag, and the round / shift / clip output stage.
module clip_mac_lane
  import clip_mac_pkg::*;
#(
  parameter int W     = CM_W,
  parameter int ACC_W = CM_ACC_W,
  parameter int OUT_W = CM_OUT_W,
  parameter int SH_W  = CM_SH_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    signed_a,
  input  logic [W-1:0]            a,
  input  logic signed [W-1:0]     b,
  input  logic                    vld_p1,
  input  logic                    last_p1,
  input  logic                    vld_p2,
  input  logic [SH_W-1:0]         rsh_p2,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

  localparam logic signed [63:0] ACC_MAX64 = sat_max(ACC_W);
  localparam logic signed [63:0] ACC_MIN64 = sat_min(ACC_W);
  localparam logic signed [63:0] OUT_MAX64 = sat_max(OUT_W);
  localparam logic signed [63:0] OUT_MIN64 = sat_min(OUT_W);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_MAX64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_MIN64[ACC_W-1:0];
  // Output limits widened to the rounding width so comparisons are exact
  localparam logic signed [ACC_W:0]   OUT_HI  = OUT_MAX64[ACC_W:0];
  localparam logic signed [ACC_W:0]   OUT_LO  = OUT_MIN64[ACC_W:0];

  // Overflow of an ACC_W+1 bit sum shows as disagreeing top two bits
  function automatic logic acc_ovf(input logic signed [ACC_W:0] v);
    return v[ACC_W] ^ v[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_sat(input logic signed [ACC_W:0] v);
    if (v[ACC_W] ^ v[ACC_W-1]) begin
      return v[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    return v[ACC_W-1:0];
  endfunction

  // Round-half-up then arithmetic shift. Shifts beyond ACC_W give the same
  // (zero) answer as a shift of exactly ACC_W, so the amount is clamped there
  // to keep the half-LSB term inside the ACC_W+1 bit adder.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] v,
                                                        input logic [SH_W-1:0]      sh);
    int                    sh_i;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] sum;
    sh_i = int'(sh);
    if (sh_i > ACC_W) sh_i = ACC_W;
    half = '0;
    if (sh_i > 0) half = {{ACC_W{1'b0}}, 1'b1} << (sh_i - 1);
    sum = {v[ACC_W-1], v} + half;
    return sum >>> sh_i;
  endfunction

  function automatic logic signed [OUT_W-1:0] clip_out(input logic signed [ACC_W:0] r);
    if (r > OUT_HI) return OUT_HI[OUT_W-1:0];
    if (r < OUT_LO) return OUT_LO[OUT_W-1:0];
    return r[OUT_W-1:0];
  endfunction

  function automatic logic clip_hit(input logic signed [ACC_W:0] r);
    return (r > OUT_HI) || (r < OUT_LO);
  endfunction

  logic                    sa;
  logic signed [2*W:0]     a_x;
  logic signed [2*W:0]     b_x;
  logic signed [2*W:0]     prod_full;
  logic signed [2*W-1:0]   prod_p1;
  logic signed [ACC_W-1:0] acc;
  logic                    sticky;
  logic signed [ACC_W:0]   sum_p1;
  logic signed [ACC_W-1:0] acc_nxt;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc_p2;
  logic                    stk_p2;
  logic signed [ACC_W:0]   rnd_p2;

  // in0 is sign- or zero-extended by mode; the exact product fits in 2*W bits
  assign sa        = signed_a & a[W-1];
  assign a_x       = {{(W+1){sa}}, a};
  assign b_x       = {{(W+1){b[W-1]}}, b};
  assign prod_full = a_x * b_x;

  // ---- S0 -> S1: register the lane product
  // Product capture for every advancing beat; validity travels in the top.
  always_ff @(posedge clk) begin
    if (en) prod_p1 <= prod_full[2*W-1:0];
  end

  // ---- S1 -> S2: saturating accumulate
  assign sum_p1  = {acc[ACC_W-1], acc} + {{(ACC_W+1-2*W){prod_p1[2*W-1]}}, prod_p1};
  assign acc_nxt = acc_sat(sum_p1);
  assign ovf     = acc_ovf(sum_p1);

  // Accumulator and sticky flag: cleared when a burst closes, else accumulate.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (en && vld_p1) begin
      if (last_p1) begin
        acc    <= '0;
        sticky <= 1'b0;
      end else begin
        acc    <= acc_nxt;
        sticky <= sticky | ovf;
      end
    end
  end

  // Forward the closing burst total and its saturation history to S3.
  always_ff @(posedge clk) begin
    if (en && vld_p1 && last_p1) begin
      acc_p2 <= acc_nxt;
      stk_p2 <= sticky | ovf;
    end
  end

  // ---- S2 -> S3: round, shift, clip and register the lane result
  assign rnd_p2 = round_shift(acc_p2, rsh_p2);

  // Output register: loads a finished burst, otherwise holds for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      sat <= 1'b0;
    end else if (en && vld_p2) begin
      res <= clip_out(rnd_p2);
      sat <= stk_p2 | clip_hit(rnd_p2);
    end
  end

endmodule

// File: rtl/clip_mac_tc.sv
// Multi-lane pipelined multiply-accumulate-clip unit with valid/ready on both
// sides. Control pipeline lives here; per-lane datapath in clip_mac_lane.
module clip_mac_tc
  import clip_mac_pkg::*;
#(
  parameter int W     = CM_W,
  parameter int LANES = CM_LANES,
  parameter int ACC_W = CM_ACC_W,
  parameter int OUT_W = CM_OUT_W,
  parameter int SH_W  = CM_SH_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [LANES*W-1:0]     in0,
  input  logic [LANES*W-1:0]     in1,
  input  logic [1:0]             fp_mode,
  input  logic [SH_W-1:0]        rshift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);

  logic            en;
  logic            signed_a;
  logic            vld_p1;
  logic            last_p1;
  logic [SH_W-1:0] rsh_p1;
  logic            vld_p2;
  logic [SH_W-1:0] rsh_p2;

  // The whole pipeline advances together unless a result is waiting downstream
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign signed_a = (fp_mode != FP_MODE_UNSIGNED);

  // ---- S0 -> S1 -> S2 -> S3 valid chain; only closing beats reach S2
  // Valid pipeline: a beat becomes a result only when it closes a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1 && last_p1;
      out_valid <= vld_p2;
    end
  end

  // Burst-end flag and shift amount travel alongside the beat data.
  always_ff @(posedge clk) begin
    if (en) begin
      last_p1 <= in_last;
      rsh_p1  <= rshift;
      rsh_p2  <= rsh_p1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    clip_mac_lane #(
      .W     (W),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .signed_a (signed_a),
      .a        (in0[i*W +: W]),
      .b        (in1[i*W +: W]),
      .vld_p1   (vld_p1),
      .last_p1  (last_p1),
      .vld_p2   (vld_p2),
      .rsh_p2   (rsh_p2),
      .res      (out_data[i*OUT_W +: OUT_W]),
      .sat      (out_sat[i])
    );
  end

endmodule

// File: tb/tb_clip_mac_tc.sv
// Self-checking bench for clip_mac_tc: directed scenarios plus randomized
// bursts checked against an arithmetic reference model.
module tb_clip_mac_tc;

  localparam int W     = 8;
  localparam int LANES = 4;
  localparam int ACC_W = 24;
  localparam int OUT_W = 8;
  localparam int SH_W  = 5;
  localparam int LW    = LANES * W;
  localparam int OW    = LANES * OUT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_last = 1'b0;
  logic [LW-1:0]    in0 = '0;
  logic [LW-1:0]    in1 = '0;
  logic [1:0]       fp_mode = 2'b00;
  logic [SH_W-1:0]  rshift = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OW-1:0]    out_data;
  logic [LANES-1:0] out_sat;

  clip_mac_tc #(
    .W(W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in0(in0), .in1(in1), .fp_mode(fp_mode),
    .rshift(rshift), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit drv_done = 0;

  logic [OW-1:0]    got_d[$];
  logic [LANES-1:0] got_s[$];
  logic [OW-1:0]    exp_d[$];
  logic [LANES-1:0] exp_s[$];

  logic [LW-1:0] bx0[1024];
  logic [LW-1:0] bx1[1024];
  logic [1:0]    bm[1024];

  // Record every completed output handshake (values stable before the edge)
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_s.push_back(out_sat);
    end
  end

  task automatic clear_q();
    got_d.delete(); got_s.delete(); exp_d.delete(); exp_s.delete();
  endtask

  task automatic fill_const(input int n, input logic [LW-1:0] x0, input logic [LW-1:0] x1,
                            input logic [1:0] m);
    for (int i = 0; i < n; i++) begin
      bx0[i] = x0; bx1[i] = x1; bm[i] = m;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      bx0[i] = $urandom; bx1[i] = $urandom; bm[i] = 2'($urandom_range(0, 3));
    end
  endtask

  // Reference: integer sum of products clamped to ACC_W, round-half-up shift,
  // clamp to OUT_W; the flag records any clamp within the burst.
  task automatic model_burst(input int n, input int rs);
    logic [OW-1:0]    d;
    logic [LANES-1:0] s;
    logic [W-1:0]     ua;
    logic [W-1:0]     ub;
    longint acc, a, b, r, amax, amin, omax, omin;
    bit st;
    amax = (longint'(1) <<< (ACC_W - 1)) - 1;
    amin = -(longint'(1) <<< (ACC_W - 1));
    omax = (longint'(1) <<< (OUT_W - 1)) - 1;
    omin = -(longint'(1) <<< (OUT_W - 1));
    d = '0; s = '0;
    for (int ln = 0; ln < LANES; ln++) begin
      acc = 0; st = 0;
      for (int i = 0; i < n; i++) begin
        ua = bx0[i][ln*W +: W];
        ub = bx1[i][ln*W +: W];
        if (bm[i] == 2'b00) a = longint'(ua);
        else a = longint'($signed(ua));
        b = longint'($signed(ub));
        acc = acc + a * b;
        if (acc > amax) begin acc = amax; st = 1; end
        else if (acc < amin) begin acc = amin; st = 1; end
      end
      r = acc;
      if (rs > 0) r = r + (longint'(1) <<< (rs - 1));
      r = r >>> rs;
      if (r > omax) begin r = omax; st = 1; end
      else if (r < omin) begin r = omin; st = 1; end
      d[ln*OUT_W +: OUT_W] = r[OUT_W-1:0];
      s[ln] = st;
    end
    exp_d.push_back(d);
    exp_s.push_back(s);
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded)
  task automatic send_beat(input logic [LW-1:0] x0, input logic [LW-1:0] x1,
                           input logic [1:0] m, input logic l, input logic [SH_W-1:0] s);
    bit ok;
    bit done;
    in0 = x0; in1 = x1; fp_mode = m; in_last = l; rshift = s; in_valid = 1'b1;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      #1 ok = in_ready;
      @(posedge clk); #1;
      if (ok) done = 1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL send_beat: in_ready=%0b never 1 within 300 cycles", in_ready);
    end
  endtask

  task automatic send_burst(input int n, input int rs);
    model_burst(n, rs);
    for (int i = 0; i < n; i++) begin
      send_beat(bx0[i], bx1[i], bm[i], (i == n - 1),
                (i == n - 1) ? SH_W'(rs) : SH_W'($urandom_range(0, 31)));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1; in0 = $urandom; in1 = $urandom;
    fp_mode = 2'b01;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_sat !== '0) begin fails++; $display("FAIL reset_out_sat: got %h want 0", out_sat); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    repeat (8) begin @(posedge clk); #1; end
    checks++; if (got_d.size() !== 0) begin fails++; $display("FAIL reset_no_output: got %0d results want 0", got_d.size()); end
  endtask

  task automatic test_mode_select();
    logic [OW-1:0]    want_d;
    logic [LANES-1:0] want_s;
    for (int m = 0; m < 2; m++) begin
      clear_q();
      want_d = (m == 0) ? {LANES{8'h7F}} : {LANES{8'hFE}};
      want_s = (m == 0) ? {LANES{1'b1}} : {LANES{1'b0}};
      send_beat({LANES{8'hFF}}, {LANES{8'h02}}, 2'(m), 1'b1, '0);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mode%0d_lat_t1: out_valid=%0b want 0", m, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mode%0d_lat_t2: out_valid=%0b want 0", m, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mode%0d_lat_t3: out_valid=%0b want 1", m, out_valid); end
      checks++; if (out_data !== want_d) begin fails++; $display("FAIL mode%0d_data: got %h want %h", m, out_data, want_d); end
      checks++; if (out_sat !== want_s) begin fails++; $display("FAIL mode%0d_sat: got %h want %h", m, out_sat, want_s); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst_round();
    clear_q();
    fill_const(4, {LANES{8'd10}}, {LANES{8'd3}}, 2'b01);
    send_burst(4, 2);
    fill_const(1, {LANES{8'd5}}, {LANES{8'd5}}, 2'b01);
    send_burst(1, 0);
    for (int k = 0; k < 50 && got_d.size() < 2; k++) begin @(posedge clk); #1; end
    checks++;
    if (got_d.size() !== 2) begin
      fails++; $display("FAIL round_count: got %0d results want 2", got_d.size());
    end else begin
      checks++; if (got_d[0] !== {LANES{8'd30}}) begin fails++; $display("FAIL round_data: got %h want %h", got_d[0], {LANES{8'd30}}); end
      checks++; if (got_s[0] !== '0) begin fails++; $display("FAIL round_sat: got %h want 0", got_s[0]); end
      checks++; if (got_d[1] !== {LANES{8'd25}}) begin fails++; $display("FAIL b2b_data: got %h want %h", got_d[1], {LANES{8'd25}}); end
      checks++; if (got_s[1] !== '0) begin fails++; $display("FAIL b2b_sat: got %h want 0", got_s[1]); end
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready = 1'b0;
    fill_rand(1); send_burst(1, $urandom_range(0, 12));
    fill_rand(1); send_burst(1, $urandom_range(0, 12));
    fill_rand(3);
    fork
      send_burst(3, $urandom_range(0, 12));
      begin
        for (int k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
        for (int k = 0; k < 10; k++) begin
          checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %0b want 0 (cycle %0d)", in_ready, k); end
          checks++; if (out_valid !== 1'b1 || out_data !== exp_d[0]) begin
            fails++; $display("FAIL bp_hold: valid=%0b data=%h want valid=1 data=%h", out_valid, out_data, exp_d[0]);
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && got_d.size() < 3; k++) begin @(posedge clk); #1; end
    checks++; if (got_d.size() !== 3) begin fails++; $display("FAIL bp_count: got %0d results want 3", got_d.size()); end
    for (int k = 0; k < 3 && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k]) begin
        fails++; $display("FAIL bp_result%0d: got %h/%h want %h/%h", k, got_d[k], got_s[k], exp_d[k], exp_s[k]);
      end
    end
  endtask

  task automatic test_acc_sat();
    clear_q();
    fill_const(600, {LANES{8'h80}}, {LANES{8'h80}}, 2'b01);
    send_burst(600, 16);
    for (int k = 0; k < 50 && got_d.size() < 1; k++) begin @(posedge clk); #1; end
    checks++;
    if (got_d.size() !== 1) begin
      fails++; $display("FAIL accsat_count: got %0d results want 1", got_d.size());
    end else begin
      checks++; if (got_d[0] !== {LANES{8'h7F}}) begin fails++; $display("FAIL accsat_data: got %h want %h", got_d[0], {LANES{8'h7F}}); end
      checks++; if (got_s[0] !== {LANES{1'b1}}) begin fails++; $display("FAIL accsat_flag: got %h want f", got_s[0]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_q();
    send_beat({LANES{8'd7}}, {LANES{8'd7}}, 2'b01, 1'b0, '0);
    send_beat({LANES{8'd7}}, {LANES{8'd7}}, 2'b01, 1'b0, '0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fill_const(1, {LANES{8'd5}}, {LANES{8'd5}}, 2'b01);
    send_burst(1, 0);
    for (int k = 0; k < 50 && got_d.size() < 1; k++) begin @(posedge clk); #1; end
    checks++;
    if (got_d.size() !== 1) begin
      fails++; $display("FAIL midrst_count: got %0d results want 1", got_d.size());
    end else begin
      checks++; if (got_d[0] !== {LANES{8'd25}}) begin fails++; $display("FAIL midrst_data: got %h want %h", got_d[0], {LANES{8'd25}}); end
      checks++; if (got_s[0] !== '0) begin fails++; $display("FAIL midrst_sat: got %h want 0", got_s[0]); end
    end
  endtask

  task automatic test_random();
    clear_q();
    drv_done = 0;
    fork
      begin
        for (int bst = 0; bst < 25; bst++) begin
          int n;
          n = $urandom_range(1, 6);
          fill_rand(n);
          send_burst(n, $urandom_range(0, 31));
        end
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 100 && got_d.size() < exp_d.size(); k++) begin @(posedge clk); #1; end
    checks++; if (got_d.size() !== exp_d.size()) begin fails++; $display("FAIL rand_count: got %0d results want %0d", got_d.size(), exp_d.size()); end
    for (int k = 0; k < exp_d.size() && k < got_d.size(); k++) begin
      checks++;
      if (got_d[k] !== exp_d[k] || got_s[k] !== exp_s[k]) begin
        fails++; $display("FAIL rand_result%0d: got %h/%h want %h/%h", k, got_d[k], got_s[k], exp_d[k], exp_s[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_select();
    test_burst_round();
    test_backpressure();
    test_acc_sat();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
